// File: rtl/vga_region_address_gen.sv
// Raster-order region scanner: walks a clipped rectangle of an H_RES x V_RES
// screen and emits one (x, y, mem_address) beat per pixel over valid/ready.
// The base address takes one constant multiply during SETUP; after that the
// address advances by increment (+1 per column, +H_RES per row).
module vga_region_address_gen #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W-1:0]    w,
  input  logic [Y_W-1:0]    h,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] mem_address,
  output logic              last,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FIN} state_t;

  state_t state, state_next;

  // Request latched at acceptance; later input changes are ignored
  logic [X_W-1:0]    x0_l, w_l;
  logic [Y_W-1:0]    y0_l, h_l;

  // Scan position and clipped region bounds
  logic [X_W-1:0]    x_r, x_end;
  logic [Y_W-1:0]    y_r, y_end;
  logic [ADDR_W-1:0] addr_r, row_base;

  // Clipping / base computation, consumed in SETUP
  logic              region_empty;
  logic [X_W:0]      x_room, we;
  logic [Y_W:0]      y_room, he;
  logic [X_W-1:0]    x_end_calc;
  logic [Y_W-1:0]    y_end_calc;
  logic [ADDR_W-1:0] base;

  logic              last_beat;
  logic              fire;

  // Clip the latched request to the screen and derive the start address
  always_comb begin
    region_empty = ({1'b0, x0_l} >= (X_W+1)'(H_RES)) ||
                   ({1'b0, y0_l} >= (Y_W+1)'(V_RES)) ||
                   (w_l == '0) || (h_l == '0);
    x_room     = (X_W+1)'(H_RES) - {1'b0, x0_l};
    y_room     = (Y_W+1)'(V_RES) - {1'b0, y0_l};
    we         = ({1'b0, w_l} < x_room) ? {1'b0, w_l} : x_room;
    he         = ({1'b0, h_l} < y_room) ? {1'b0, h_l} : y_room;
    // Inclusive end coordinates always fit, since they are < H_RES / V_RES
    x_end_calc = X_W'({1'b0, x0_l} + we - (X_W+1)'(1));
    y_end_calc = Y_W'({1'b0, y0_l} + he - (Y_W+1)'(1));
    base       = ADDR_W'(y0_l) * ADDR_W'(H_RES) + ADDR_W'(x0_l);
  end

  assign last_beat = (state == RUN) && (x_r == x_end) && (y_r == y_end);
  assign fire      = out_valid && out_ready;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = region_empty ? FIN : RUN;
      RUN:     if (fire && last_beat) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request latch, region load, incremental address walk
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x0_l     <= '0;
      y0_l     <= '0;
      w_l      <= '0;
      h_l      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      x_end    <= '0;
      y_end    <= '0;
      addr_r   <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x0_l <= x0;
          y0_l <= y0;
          w_l  <= w;
          h_l  <= h;
        end
        SETUP: if (!region_empty) begin
          x_r      <= x0_l;
          y_r      <= y0_l;
          addr_r   <= base;
          row_base <= base;
          x_end    <= x_end_calc;
          y_end    <= y_end_calc;
        end
        RUN: if (fire && !last_beat) begin
          if (x_r == x_end) begin
            x_r      <= x0_l;
            y_r      <= y_r + Y_W'(1);
            row_base <= row_base + ADDR_W'(H_RES);
            addr_r   <= row_base + ADDR_W'(H_RES);
          end else begin
            x_r    <= x_r + X_W'(1);
            addr_r <= addr_r + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == RUN);
    done      = (state == FIN);
    last      = last_beat;
  end

  assign x           = x_r;
  assign y           = y_r;
  assign mem_address = addr_r;

endmodule

// File: tb/tb_vga_region_address_gen.sv
// Bench for vga_region_address_gen: a region model builds the expected beat
// list with plain loops; a negedge process compares every offered beat.
module tb_vga_region_address_gen;

  localparam int H1 = 320, V1 = 240;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;

  logic        start = 1'b0;
  logic [8:0]  x0_s = '0, w_s = '0;
  logic [7:0]  y0_s = '0, h_s = '0;
  logic        out_ready = 1'b1;
  logic        busy, out_valid, last, done;
  logic [8:0]  x_o;
  logic [7:0]  y_o;
  logic [16:0] addr_o;

  logic        start2 = 1'b0;
  logic [9:0]  x0_2 = '0, w_2 = '0;
  logic [8:0]  y0_2 = '0, h_2 = '0;
  logic        busy2, valid2, last2, done2;
  logic [9:0]  x_o2;
  logic [8:0]  y_o2;
  logic [18:0] addr_o2;

  int errors = 0;
  int checks = 0;

  typedef struct { int x; int y; int addr; int last; } beat_t;
  beat_t exp_q[$];
  bit    model_on = 1'b0;

  always #5 clock = ~clock;

  vga_region_address_gen dut (
    .clock(clock), .resetn(resetn), .start(start),
    .x0(x0_s), .y0(y0_s), .w(w_s), .h(h_s),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .x(x_o), .y(y_o), .mem_address(addr_o), .last(last), .done(done)
  );

  vga_region_address_gen #(.H_RES(640), .V_RES(480), .X_W(10), .Y_W(9), .ADDR_W(19)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2),
    .x0(x0_2), .y0(y0_2), .w(w_2), .h(h_2),
    .busy(busy2), .out_valid(valid2), .out_ready(1'b1),
    .x(x_o2), .y(y_o2), .mem_address(addr_o2), .last(last2), .done(done2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats: every pixel of the screen-clipped rectangle, raster order
  task automatic model_build(input int mx0, input int my0, input int mw, input int mh,
                             input int hres, input int vres);
    int we, he;
    beat_t b;
    exp_q.delete();
    if (mx0 >= hres || my0 >= vres || mw == 0 || mh == 0) return;
    we = (mw < hres - mx0) ? mw : hres - mx0;
    he = (mh < vres - my0) ? mh : vres - my0;
    for (int yy = my0; yy < my0 + he; yy++)
      for (int xx = mx0; xx < mx0 + we; xx++) begin
        b.x = xx; b.y = yy; b.addr = yy * hres + xx;
        b.last = (xx == mx0 + we - 1 && yy == my0 + he - 1) ? 1 : 0;
        exp_q.push_back(b);
      end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  // Compare every offered beat (stalled or transferring) against the model
  always @(negedge clock) begin
    if (resetn && model_on) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("beat_x", x_o, exp_q[0].x);
          chk("beat_y", y_o, exp_q[0].y);
          chk("beat_addr", addr_o, exp_q[0].addr);
          chk("beat_last", last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) chk("done_with_beats_left", exp_q.size(), 0);
    end
  end

  // One scan from an IDLE cycle; optionally pulse start again mid-scan
  task automatic run_scan(input int sx0, input int sy0, input int sw, input int sh,
                          input int mode, input bit poke);
    int cyc, first_valid, done_cyc, n;
    model_build(sx0, sy0, sw, sh, H1, V1);
    n = exp_q.size();
    model_on = 1'b1;
    x0_s = 9'(sx0); y0_s = 8'(sy0); w_s = 9'(sw); h_s = 8'(sh);
    start = 1'b1;
    out_ready = ready_for(mode, 0);
    cyc = 0; first_valid = -1; done_cyc = -1;
    while (cyc < 200 && done_cyc < 0) begin
      @(posedge clock); #1;
      cyc++;
      start = poke && (cyc == 4);
      if (cyc == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("no_valid_in_setup", out_valid, 0);
        x0_s = 9'd1; y0_s = 8'd1; w_s = 9'd50; h_s = 8'd50;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) done_cyc = cyc;
      out_ready = ready_for(mode, cyc);
    end
    chk("done_seen", (done_cyc > 0) ? 1 : 0, 1);
    chk("all_beats_consumed", exp_q.size(), 0);
    if (n > 0) chk("first_valid_latency", first_valid, 2);
    else       chk("no_valid_empty", first_valid, -1);
    if (mode == 0 && !poke) chk("done_cycle", done_cyc, n + 2);
    @(posedge clock); #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    model_on = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    // Pin the model with hand-computed addresses
    model_build(10, 2, 3, 2, H1, V1);
    chk("model_size", exp_q.size(), 6);
    chk("model_a0", exp_q[0].addr, 650);
    chk("model_a3", exp_q[3].addr, 970);
    chk("model_a5", exp_q[5].addr, 972);
    chk("model_last5", exp_q[5].last, 1);
    model_build(318, 239, 5, 4, H1, V1);
    chk("model_clip_size", exp_q.size(), 2);
    chk("model_clip_a0", exp_q[0].addr, 76798);
    chk("model_clip_a1", exp_q[1].addr, 76799);
    exp_q.delete();

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_addr2", addr_o2, 0);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    run_scan(10, 2, 3, 2, 0, 1'b0);
    run_scan(10, 2, 3, 2, 1, 1'b0);
    run_scan(318, 239, 5, 4, 0, 1'b0);
    run_scan(10, 2, 0, 2, 0, 1'b0);
    run_scan(320, 2, 3, 2, 0, 1'b0);
    run_scan(10, 2, 3, 2, 0, 1'b1);

    // Single-pixel corner of a 640x480 screen
    x0_2 = 10'd639; y0_2 = 9'd479; w_2 = 10'd1; h_2 = 9'd1; start2 = 1'b1;
    @(posedge clock); #1; start2 = 1'b0;
    chk("hd_setup_busy", busy2, 1);
    @(posedge clock); #1;
    chk("hd_valid", valid2, 1);
    chk("hd_x", x_o2, 639);
    chk("hd_y", y_o2, 479);
    chk("hd_addr", addr_o2, 307199);
    chk("hd_last", last2, 1);
    @(posedge clock); #1;
    chk("hd_valid_after", valid2, 0);
    chk("hd_done", done2, 1);
    @(posedge clock); #1;

    // Mid-scan asynchronous reset aborts without a done pulse
    model_build(10, 2, 3, 2, H1, V1);
    model_on = 1'b1;
    x0_s = 9'd10; y0_s = 8'd2; w_s = 9'd3; h_s = 8'd2; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("mid_scan_valid", out_valid, 1);
    @(negedge clock); #2;
    model_on = 1'b0;
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", last, 0);
    chk("abort_done", done, 0);
    chk("abort_x", x_o, 0);
    chk("abort_y", y_o, 0);
    chk("abort_addr", addr_o, 0);
    exp_q.delete();
    @(posedge clock); #1;
    chk("abort_hold_done", done, 0);
    @(negedge clock); #2; resetn = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_done", done, 0);
    chk("post_reset_busy", busy, 0);
    run_scan(10, 2, 3, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
